pwm_fade_ctrl: RTL and testbench

Duty-cycle sequencer for the PWM generator. Accepts a fade command (target duty, step size, step interval) over a valid/ready handshake, then walks the generator's duty input from its current value to the target. It moves one step every N PWM periods, never overshooting. It sits between the control logic and the PWM core: it consumes the core's end-of-period tick and owns the core's duty input.

---
 rtl/pwm_fade_ctrl_if.sv | 27 ++
 rtl/pwm_fade_ctrl.sv | 127 ++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_fade_ctrl_if.sv
// rtl/pwm_fade_ctrl_if.sv - fade command handshake bundle between control logic and the fade sequencer
interface pwm_fade_ctrl_if #(
  parameter int DW = 8,
  parameter int IW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_target;
  logic [DW-1:0] cmd_step;
  logic [IW-1:0] cmd_interval;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_step,
    output cmd_interval,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_step,
    input  cmd_interval,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - walks the PWM duty toward a commanded target, one step every N periods
module pwm_fade_ctrl #(
  parameter int DW = 8,
  parameter int IW = 8
) (
  input  logic              clk,
  input  logic              rst,
  pwm_fade_ctrl_if.slave    cmd,
  input  logic              abort,
  input  logic              period_tick,
  output logic [DW-1:0]     duty,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [DW-1:0] duty_q;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] target_q;
  logic [DW-1:0] step_q;
  logic [IW-1:0] interval_q;
  logic [IW-1:0] tick_cnt_q;
  logic          up_q;

  logic [DW-1:0] step_d;
  logic [IW-1:0] interval_d;
  logic [DW-1:0] duty_d;
  logic [DW:0]   sum_w;
  logic [DW:0]   diff_w;
  logic          tick_last;

  assign cmd.cmd_ready = (state_q == S_IDLE) && rst;
  assign duty          = duty_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // One extra bit on sum/difference catches wrap so the result saturates at the target.
  always_comb begin
    step_d     = (cmd.cmd_step == '0) ? DW'(1) : cmd.cmd_step;
    interval_d = (cmd.cmd_interval == '0) ? IW'(1) : cmd.cmd_interval;
    sum_w      = {1'b0, duty_q} + {1'b0, step_q};
    diff_w     = {1'b0, duty_q} - {1'b0, step_q};
    duty_d     = duty_q;
    if (up_q) begin
      duty_d = (sum_w >= {1'b0, target_q}) ? target_q : sum_w[DW-1:0];
    end else begin
      duty_d = (diff_w[DW] || (diff_w[DW-1:0] <= target_q)) ? target_q : diff_w[DW-1:0];
    end
    tick_last = (tick_cnt_q == (interval_q - IW'(1)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      duty_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      tick_cnt_q <= '0;
      up_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (cmd.cmd_valid) begin
            target_q   <= cmd.cmd_target;
            step_q     <= step_d;
            interval_q <= interval_d;
            tick_cnt_q <= '0;
            up_q       <= (cmd.cmd_target > duty_q);
            if (cmd.cmd_target == duty_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          // abort outranks a coincident tick: duty is frozen where it stands.
          if (abort) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            tick_cnt_q <= '0;
          end else if (period_tick) begin
            if (tick_last) begin
              duty_q     <= duty_d;
              tick_cnt_q <= '0;
              if (duty_d == target_q) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + IW'(1);
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - scoreboard bench for pwm_fade_ctrl
module tb_pwm_fade_ctrl;
  localparam int DW = 8;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          abort = 1'b0;
  logic          period_tick = 1'b0;
  logic [DW-1:0] duty;
  logic          busy;
  logic          done;

  pwm_fade_ctrl_if #(.DW(DW), .IW(IW)) cmd_if ();

  pwm_fade_ctrl #(.DW(DW), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .abort       (abort),
    .period_tick (period_tick),
    .duty        (duty),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int is_done;
    int val;
    int tick;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  n_pass = 0;
  int  n_total = 0;
  int  ticks_seen = 0;
  int  mdl_duty = 0;
  int  last_duty = 0;
  int  prev_duty = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) if (period_tick) ticks_seen <= ticks_seen + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(duty) != prev_duty) begin
        if (sb.size() == 0) chk("unexpected_duty_change", int'(duty), prev_duty);
        else begin
          mon_e = sb.pop_front();
          chk("event_kind_step", 0, mon_e.is_done);
          chk("duty_value", int'(duty), mon_e.val);
          chk("step_tick_index", ticks_seen, mon_e.tick);
          last_duty = mon_e.val;
        end
      end
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", int'(done), 0);
        else begin
          mon_e = sb.pop_front();
          chk("event_kind_done", 1, mon_e.is_done);
          chk("duty_at_done", int'(duty), mon_e.val);
          chk("busy_during_done", int'(busy), 0);
        end
      end
    end
    prev_duty = int'(duty);
  end

  // Reference: the whole fade is predicted at acceptance as a list of duty values and tick indices.
  task automatic push_cmd(input int t, input int s, input int i);
    int v, st, iv, k, base;
    bit up;
    v    = mdl_duty;
    st   = (s == 0) ? 1 : s;
    iv   = (i == 0) ? 1 : i;
    up   = (t > v);
    base = ticks_seen;
    k    = 0;
    while (v != t) begin
      k++;
      if (up) v = (v + st > t) ? t : v + st;
      else    v = (v - st < t) ? t : v - st;
      sb.push_back('{0, v, base + k * iv});
    end
    sb.push_back('{1, t, 0});
    mdl_duty = t;
  endtask

  task automatic send_cmd(input int t, input int s, input int i);
    int n = 0;
    int exp_busy;
    @(negedge clk);
    while (!cmd_if.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_if.cmd_ready) begin
      chk("cmd_ready_timeout", int'(cmd_if.cmd_ready), 1);
      return;
    end
    cmd_if.cmd_target   = 8'(t);
    cmd_if.cmd_step     = 8'(s);
    cmd_if.cmd_interval = 8'(i);
    cmd_if.cmd_valid    = 1'b1;
    exp_busy = (t != mdl_duty) ? 1 : 0;
    push_cmd(t, s, i);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    chk("busy_after_accept", int'(busy), exp_busy);
  endtask

  task automatic tick(input int gap);
    @(negedge clk);
    period_tick = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() > 0 || !cmd_if.cmd_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    chk("ready_after_fade", int'(cmd_if.cmd_ready), 1);
  endtask

  task automatic run_fade(input int gmin, input int gmax);
    int n = 0;
    while (sb.size() > 0 && n < 1500) begin
      tick($urandom_range(gmax, gmin));
      n++;
    end
    wait_idle();
  endtask

  initial begin
    cmd_if.cmd_valid    = 1'b0;
    cmd_if.cmd_target   = '0;
    cmd_if.cmd_step     = '0;
    cmd_if.cmd_interval = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_duty", int'(duty), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_ready", int'(cmd_if.cmd_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    chk("release_duty", int'(duty), 0);
    chk("release_ready", int'(cmd_if.cmd_ready), 1);

    send_cmd(100, 30, 2);  run_fade(8, 8);
    send_cmd(10, 40, 1);   run_fade(1, 5);
    send_cmd(200, 255, 1); run_fade(1, 3);
    send_cmd(250, 255, 1); run_fade(1, 3);
    send_cmd(0, 255, 1);   run_fade(1, 3);
    send_cmd(3, 0, 0);     run_fade(0, 3);
    send_cmd(3, 7, 5);     wait_idle();
    send_cmd(0, 3, 1);     run_fade(1, 3);

    send_cmd(100, 30, 1);
    tick(3);
    tick(3);
    chk("pre_abort_duty", int'(duty), 60);
    @(negedge clk);
    abort = 1'b1;
    period_tick = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    period_tick = 1'b0;
    sb.delete();
    mdl_duty = last_duty;
    chk("abort_ready", int'(cmd_if.cmd_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_duty", int'(duty), 60);
    repeat (5) @(negedge clk);
    chk("abort_duty_hold", int'(duty), mdl_duty);
    send_cmd(100, 30, 1);  run_fade(1, 3);
    send_cmd(0, 100, 1);   run_fade(1, 3);

    send_cmd(120, 30, 1);
    tick(3);
    tick(3);
    tick(3);
    chk("pre_reset_duty", int'(duty), 90);
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b0;
    cmd_if.cmd_valid    = 1'b1;
    cmd_if.cmd_target   = 8'd50;
    cmd_if.cmd_step     = 8'd25;
    cmd_if.cmd_interval = 8'd1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      #1;
      chk("midreset_duty", int'(duty), 0);
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_done", int'(done), 0);
      chk("midreset_ready", int'(cmd_if.cmd_ready), 0);
    end
    sb.delete();
    mdl_duty = 0;
    last_duty = 0;
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    push_cmd(50, 25, 1);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    chk("post_reset_accept_busy", int'(busy), 1);
    run_fade(1, 3);

    for (int c = 0; c < 12; c++) begin
      int t, s, i, pre;
      pre = $urandom_range(2, 0);
      repeat (pre) tick(1);
      t = ($urandom_range(4, 0) == 0) ? mdl_duty : $urandom_range(255, 0);
      s = $urandom_range(40, 0);
      i = $urandom_range(3, 0);
      send_cmd(t, s, i);
      run_fade(0, 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
